srf02_range_reader: RTL and testbench

Reads the 16-bit range result from the SRF02 ultrasonic sensor over I2C. It is the downstream companion of the I2C ranging-command writer, which issues command 0x51 (range in cm) to register 0. Once the sensor has finished ranging, this block performs a pointer write to register 0x02, a repeated START, and a 2-byte read. It then presents the range with a one-cycle `done` pulse. Bit timing and line driving match the command writer, so both can share the bus through the top-level mux.

---
 rtl/srf02_range_reader_if.sv | 19 +
 rtl/srf02_range_reader.sv | 151 +++++++++++++++
 tb/tb_srf02_range_reader.sv | 309 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/srf02_range_reader_if.sv
// Request/result bundle between the SRF02 range reader and its caller.
// The caller drives start; the reader reports busy, done, range and ack_err.
interface srf02_range_reader_if;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] range;
  logic        ack_err;

  modport master (
    output start,
    input  busy, done, range, ack_err
  );

  modport slave (
    input  start,
    output busy, done, range, ack_err
  );
endinterface

// File: rtl/srf02_range_reader.sv
// SRF02 range reader: pointer write to REG_PTR, repeated START, 2-byte read.
// 50 slots of 128 clocks each; lines are only pulled low or released.
module srf02_range_reader #(
  parameter logic [7:0] ADDR_W  = 8'hE0,
  parameter logic [7:0] REG_PTR = 8'h02
) (
  input  logic                       clk,
  input  logic                       reset,
  srf02_range_reader_if.slave        bus,
  inout  wire                        i2c_sclk,
  inout  wire                        i2c_sdat
);

  localparam logic [7:0] ADDR_R = ADDR_W | 8'h01;

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [6:0]  div_q, div_d;
  logic [5:0]  slot_q, slot_d;
  logic        clk_en_q, clk_en_d;
  logic        sda_low_q, sda_low_d;
  logic [2:0]  acks_q, acks_d;
  logic [15:0] shift_q, shift_d;
  logic [15:0] range_q, range_d;
  logic        ack_err_q, ack_err_d;
  logic        done_q, done_d;

  logic sda_in;
  logic sda_bit;
  logic s_aw, s_reg, s_ar, s_rd;

  assign sda_in = i2c_sdat;

  assign s_aw  = (slot_q >= 6'd1)  && (slot_q <= 6'd8);
  assign s_reg = (slot_q >= 6'd10) && (slot_q <= 6'd17);
  assign s_ar  = (slot_q >= 6'd21) && (slot_q <= 6'd28);
  assign s_rd  = ((slot_q >= 6'd30) && (slot_q <= 6'd37))
              || ((slot_q >= 6'd39) && (slot_q <= 6'd46));

  // Line level the master wants in the current slot (1 = released)
  always_comb begin
    sda_bit = 1'b1;
    unique case (1'b1)
      slot_q == 6'd0,
      slot_q == 6'd20,
      slot_q == 6'd38,
      slot_q == 6'd48: sda_bit = 1'b0;
      s_aw:  sda_bit = ADDR_W[3'(6'd8 - slot_q)];
      s_reg: sda_bit = REG_PTR[3'(6'd17 - slot_q)];
      s_ar:  sda_bit = ADDR_R[3'(6'd28 - slot_q)];
      default: sda_bit = 1'b1;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    slot_d    = slot_q;
    clk_en_d  = clk_en_q;
    sda_low_d = sda_low_q;
    acks_d    = acks_q;
    shift_d   = shift_q;
    range_d   = range_q;
    ack_err_d = ack_err_q;
    done_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = RUN;
          div_d     = 7'd0;
          slot_d    = 6'd0;
          acks_d    = 3'b000;
          clk_en_d  = 1'b0;
          sda_low_d = 1'b0;
        end
      end
      RUN: begin
        div_d = div_q + 7'd1;
        if (div_q == 7'd31) begin
          sda_low_d = !sda_bit;
        end
        if (div_q == 7'd95) begin
          if (slot_q == 6'd9)  acks_d[0] = sda_in;
          if (slot_q == 6'd18) acks_d[1] = sda_in;
          if (slot_q == 6'd29) acks_d[2] = sda_in;
          if (s_rd) shift_d = {shift_q[14:0], sda_in};
        end
        if (div_q == 7'd127) begin
          slot_d = slot_q + 6'd1;
          if (slot_q == 6'd0 || slot_q == 6'd20) begin
            clk_en_d = 1'b1;
          end
          if (slot_q == 6'd19 || slot_q == 6'd48) begin
            clk_en_d = 1'b0;
          end
          if (slot_q == 6'd49) begin
            state_d   = IDLE;
            slot_d    = 6'd0;
            clk_en_d  = 1'b0;
            sda_low_d = 1'b0;
            done_d    = 1'b1;
            if (acks_q == 3'b000) begin
              range_d   = shift_q;
              ack_err_d = 1'b0;
            end else begin
              ack_err_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      div_q     <= 7'd0;
      slot_q    <= 6'd0;
      clk_en_q  <= 1'b0;
      sda_low_q <= 1'b0;
      acks_q    <= 3'b000;
      shift_q   <= 16'h0000;
      range_q   <= 16'h0000;
      ack_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      slot_q    <= slot_d;
      clk_en_q  <= clk_en_d;
      sda_low_q <= sda_low_d;
      acks_q    <= acks_d;
      shift_q   <= shift_d;
      range_q   <= range_d;
      ack_err_q <= ack_err_d;
      done_q    <= done_d;
    end
  end

  // Line drivers come straight from reset-cleared state, so reset frees them at once
  assign i2c_sclk = (state_q == RUN && clk_en_q && !div_q[6]) ? 1'b0 : 1'bz;
  assign i2c_sdat = sda_low_q ? 1'b0 : 1'bz;

  assign bus.busy    = (state_q == RUN);
  assign bus.done    = done_q;
  assign bus.range   = range_q;
  assign bus.ack_err = ack_err_q;

endmodule

// File: tb/tb_srf02_range_reader.sv
// Bench for srf02_range_reader: I2C slave/monitor, transaction model,
// directed and randomized reads.
module tb_srf02_range_reader;

  logic clk = 1'b0;
  logic rst_n;
  wire  scl;
  wire  sda;

  srf02_range_reader_if bus();

  srf02_range_reader dut (
    .clk      (clk),
    .reset    (rst_n),
    .bus      (bus),
    .i2c_sclk (scl),
    .i2c_sdat (sda)
  );

  pullup (scl);
  pullup (sda);

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Bus events: 256 = START, 512 = STOP, 768+b = master ack bit, else byte
  int exp_seq [8] = '{256, 'hE0, 'h02, 256, 'hE1, 768, 769, 512};
  int exp_t   [3] = '{32, 2592, 6304};

  // I2C slave plus bus monitor
  logic       slv_low = 1'b0;
  logic [7:0] slv_hi = 8'h00;
  logic [7:0] slv_lo = 8'h00;
  logic [2:0] slv_nack = 3'b000;
  logic [7:0] cur = 8'h00;
  logic [7:0] tx = 8'h00;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  logic       s, d, ack_ok;
  int         bitcnt = 0;
  int         ack_idx = 0;
  int         txi = 0;
  int         t_rise = 0;
  int         t_fall = 0;
  int         start_cyc = 0;
  bit         first = 1'b0;
  bit         rd = 1'b0;
  bit         pend_rd = 1'b0;
  bit         drv_rd = 1'b0;
  bit         last_ma = 1'b0;
  bit         had_ev = 1'b1;
  bit         have_fall = 1'b0;
  bit         have_rise = 1'b0;
  int         evlog [$];
  int         ev_t [$];

  assign sda = slv_low ? 1'b0 : 1'bz;

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slv_low   = 1'b0;
      bitcnt    = 0;
      ack_idx   = 0;
      rd        = 1'b0;
      pend_rd   = 1'b0;
      first     = 1'b0;
      prev_scl  = 1'b1;
      prev_sda  = 1'b1;
      had_ev    = 1'b1;
      have_fall = 1'b0;
      have_rise = 1'b0;
    end else begin
      s = scl;
      d = sda;
      if (s && prev_scl && d != prev_sda) begin
        had_ev = 1'b1;
        ev_t.push_back(cyc - start_cyc);
        if (!d) begin
          evlog.push_back(256);
          bitcnt  = 0;
          first   = 1'b1;
          rd      = 1'b0;
          pend_rd = 1'b0;
          slv_low = 1'b0;
          cur     = 8'h00;
        end else begin
          evlog.push_back(512);
          ack_idx = 0;
          rd      = 1'b0;
        end
      end else if (s && !prev_scl) begin
        if (have_fall) chk("scl_low_len", cyc - t_fall, 64);
        t_rise    = cyc;
        have_rise = 1'b1;
        had_ev    = 1'b0;
        if (bitcnt < 8) begin
          if (!rd) cur = {cur[6:0], d};
          bitcnt++;
        end else if (bitcnt == 8) begin
          if (rd) begin
            evlog.push_back(768 + int'(d));
            last_ma = d;
          end
          bitcnt = 9;
        end
      end else if (!s && prev_scl) begin
        if (!had_ev && have_rise) chk("scl_high_len", cyc - t_rise, 64);
        t_fall    = cyc;
        have_fall = 1'b1;
        if (bitcnt == 8 && !rd) begin
          evlog.push_back(int'(cur));
          ack_ok = (ack_idx < 3) ? !slv_nack[ack_idx] : 1'b1;
          ack_idx++;
          slv_low = ack_ok;
          if (first) begin
            pend_rd = cur[0];
            drv_rd  = cur[0] && ack_ok;
            first   = 1'b0;
          end
        end else if (bitcnt == 8) begin
          slv_low = 1'b0;
        end else if (bitcnt == 9) begin
          bitcnt = 0;
          if (pend_rd) begin
            rd      = 1'b1;
            pend_rd = 1'b0;
            txi     = 0;
          end else if (rd && last_ma) begin
            rd = 1'b0;
          end
          if (rd) begin
            tx = (txi == 0) ? slv_hi : slv_lo;
            txi++;
            slv_low = drv_rd && !tx[7];
          end else begin
            slv_low = 1'b0;
          end
        end else if (rd && bitcnt >= 1 && bitcnt <= 7) begin
          slv_low = drv_rd && !tx[7 - bitcnt];
        end
      end
      prev_scl = s;
      prev_sda = d;
    end
  end

  // Transaction-level reference: fixed 6400-cycle read, result by ACK outcome
  logic        m_busy, m_done, m_err;
  logic [15:0] m_range, m_data;
  logic [2:0]  m_nack;
  int          m_left;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy  <= 1'b0;
      m_done  <= 1'b0;
      m_err   <= 1'b0;
      m_range <= 16'h0000;
      m_data  <= 16'h0000;
      m_nack  <= 3'b000;
      m_left  <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_err  <= (m_nack != 3'b000);
          if (m_nack == 3'b000) m_range <= m_data;
        end
      end else if (bus.start) begin
        m_busy <= 1'b1;
        m_left <= 6400;
        m_data <= {slv_hi, slv_lo};
        m_nack <= slv_nack;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst_n === 1'b1) begin
      chk("busy", bus.busy, m_busy);
      chk("done", bus.done, m_done);
      chk("range", bus.range, m_range);
      chk("ack_err", bus.ack_err, m_err);
    end
  end

  task automatic run_txn(input logic [7:0] hi, input logic [7:0] lo,
                         input logic [2:0] nk, input int poke,
                         input bit poke_done);
    int t0;
    bit got;
    slv_hi   = hi;
    slv_lo   = lo;
    slv_nack = nk;
    evlog.delete();
    ev_t.delete();
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    t0 = cyc;
    start_cyc = cyc;
    got = 1'b0;
    for (int k = 1; k <= 6600 && !got; k++) begin
      @(negedge clk);
      bus.start = (k == poke) || (poke_done && k == 6399);
      if (bus.done === 1'b1) begin
        got = 1'b1;
        chk("done_latency", cyc - t0, 6400);
      end
    end
    bus.start = 1'b0;
    if (!got) chk("done_timeout", 0, 1);
    chk("bus_seq_len", evlog.size(), 8);
    for (int i = 0; i < 8 && i < evlog.size(); i++)
      chk("bus_seq", evlog[i], exp_seq[i]);
    chk("sda_evt_cnt", ev_t.size(), 3);
    for (int i = 0; i < 3 && i < ev_t.size(); i++)
      chk("sda_evt_time", ev_t[i], exp_t[i]);
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_busy"}, bus.busy, 1'b0);
    chk({tag, "_done"}, bus.done, 1'b0);
    chk({tag, "_range"}, bus.range, 16'h0000);
    chk({tag, "_ackerr"}, bus.ack_err, 1'b0);
    chk({tag, "_scl"}, scl, 1'b1);
    chk({tag, "_sda"}, sda, 1'b1);
  endtask

  initial begin
    bus.start = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 reset_checks("por");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (4) @(negedge clk);

    run_txn(8'h01, 8'h2C, 3'b000, 0, 1'b0);
    chk("normal_range", bus.range, 16'h012C);
    chk("normal_ackerr", bus.ack_err, 1'b0);

    run_txn(8'h55, 8'hAA, 3'b001, 0, 1'b0);
    chk("nack_range", bus.range, 16'h012C);
    chk("nack_ackerr", bus.ack_err, 1'b1);

    run_txn(8'h12, 8'h34, 3'b000, 10 * 128 + 40, 1'b1);
    repeat (3) @(negedge clk);
    chk("busy_after_done", bus.busy, 1'b0);
    chk("poke_range", bus.range, 16'h1234);

    for (int n = 0; n < 4; n++) begin
      logic [2:0] nk;
      int pk;
      nk = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      pk = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6300) : 0;
      run_txn(8'($urandom), 8'($urandom), nk, pk, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end

    // Reset while the slave is pulling SDA low during the high byte
    slv_hi   = 8'h00;
    slv_lo   = 8'h00;
    slv_nack = 3'b000;
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    start_cyc = cyc;
    repeat (33 * 128 + 10) @(negedge clk);
    chk("pre_rst_scl", scl, 1'b0);
    chk("pre_rst_sda", sda, 1'b0);
    chk("pre_rst_busy", bus.busy, 1'b1);
    #2 rst_n = 1'b0;
    #1 reset_checks("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    run_txn(8'h00, 8'h64, 3'b000, 0, 1'b0);
    chk("post_rst_range", bus.range, 16'h0064);
    chk("post_rst_ackerr", bus.ack_err, 1'b0);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
